m_mem_arbiter: RTL and testbench

- Shares one single-ported unified memory between the instruction-fetch port (I) and the load/store port (D) of the pipelined RV32I core.
- Holds at most one outstanding memory transaction.
- Honors branch-miss flushes on the fetch side by discarding killed fetch data.
- Sits between the core's fetch/execute stages and the memory model; replaces separate imem/dmem when unified memory is built.

---
 rtl/m_mem_pkg.sv | 18 +
 rtl/m_arb_pick.sv | 25 ++
 rtl/m_mem_arbiter.sv | 119 +++++++++++
 tb/tb_m_mem_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/m_mem_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states, grant codes, default widths.
// Pure declarations; no timing or flow-control behaviour of its own.
package m_mem_pkg;

   localparam int DEF_AW = 32;
   localparam int DEF_DW = 32;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY_I  = 2'd1,
      ST_BUSY_D  = 2'd2,
      ST_BUSY_IK = 2'd3
   } state_t;

   localparam logic GNT_I = 1'b0;
   localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/m_arb_pick.sv
// Combinational 2-way picker: D wins ties unless fair mode and D had the previous grant.
// Zero latency; no backpressure, the caller decides when the pick is used.
module m_arb_pick
   import m_mem_pkg::*;
(
   input  logic i_elig,
   input  logic d_req,
   input  logic last,
   input  logic fair,
   output logic gnt_valid,
   output logic gnt_sel
);

   assign gnt_valid = i_elig | d_req;

   always_comb begin
      gnt_sel = GNT_D;
      if (i_elig && !d_req) begin
         gnt_sel = GNT_I;
      end else if (i_elig && d_req && fair && (last == GNT_D)) begin
         gnt_sel = GNT_I;
      end
   end

endmodule

// File: rtl/m_mem_arbiter.sv
// Shares one single-ported memory between fetch (I) and load/store (D), one transaction in flight.
// Grant seen in IDLE drives w_m_req next cycle; acks are combinational with w_m_ack; requesters hold until ack.
module m_mem_arbiter
   import m_mem_pkg::*;
#(
   parameter int AW   = DEF_AW,
   parameter int DW   = DEF_DW,
   parameter int FAIR = 1
) (
   input  logic            w_clk,
   input  logic            w_rst_n,
   input  logic            w_i_req,
   input  logic [AW-1:0]   w_i_addr,
   input  logic            w_i_kill,
   output logic            w_i_ack,
   output logic [DW-1:0]   w_i_rdata,
   input  logic            w_d_req,
   input  logic            w_d_we,
   input  logic [DW/8-1:0] w_d_be,
   input  logic [AW-1:0]   w_d_addr,
   input  logic [DW-1:0]   w_d_wdata,
   output logic            w_d_ack,
   output logic [DW-1:0]   w_d_rdata,
   output logic            w_m_req,
   output logic            w_m_we,
   output logic [DW/8-1:0] w_m_be,
   output logic [AW-1:0]   w_m_addr,
   output logic [DW-1:0]   w_m_wdata,
   input  logic            w_m_ack,
   input  logic [DW-1:0]   w_m_rdata,
   output logic            w_busy
);

   state_t r_state;
   state_t w_nxt;
   logic   r_last;
   logic   w_i_elig;
   logic   w_gnt_valid;
   logic   w_gnt_sel;
   logic   w_grant;

   // A fetch flushed in the same cycle it is requested must not win the memory.
   assign w_i_elig = w_i_req & ~w_i_kill;

   m_arb_pick u_pick (
      .i_elig    (w_i_elig),
      .d_req     (w_d_req),
      .last      (r_last),
      .fair      (FAIR != 0),
      .gnt_valid (w_gnt_valid),
      .gnt_sel   (w_gnt_sel)
   );

   assign w_grant = (r_state == ST_IDLE) && w_gnt_valid;

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_gnt_valid) begin
               w_nxt = (w_gnt_sel == GNT_D) ? ST_BUSY_D : ST_BUSY_I;
            end
         end
         ST_BUSY_I: begin
            if (w_m_ack) begin
               w_nxt = ST_IDLE;
            end else if (w_i_kill) begin
               w_nxt = ST_BUSY_IK;
            end
         end
         ST_BUSY_D, ST_BUSY_IK: begin
            if (w_m_ack) begin
               w_nxt = ST_IDLE;
            end
         end
         default: w_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state   <= ST_IDLE;
         r_last    <= GNT_I;
         w_m_req   <= 1'b0;
         w_m_we    <= 1'b0;
         w_m_be    <= '0;
         w_m_addr  <= '0;
         w_m_wdata <= '0;
      end else begin
         r_state <= w_nxt;
         w_m_req <= (w_nxt != ST_IDLE);
         if (w_grant) begin
            r_last <= w_gnt_sel;
            if (w_gnt_sel == GNT_D) begin
               w_m_we    <= w_d_we;
               w_m_be    <= w_d_be;
               w_m_addr  <= w_d_addr;
               w_m_wdata <= w_d_wdata;
            end else begin
               w_m_we    <= 1'b0;
               w_m_be    <= '0;
               w_m_addr  <= w_i_addr;
               w_m_wdata <= '0;
            end
         end
      end
   end

   // A kill coinciding with the memory ack swallows the fetch data.
   assign w_i_ack   = w_m_ack & (r_state == ST_BUSY_I) & ~w_i_kill;
   assign w_d_ack   = w_m_ack & (r_state == ST_BUSY_D);
   assign w_i_rdata = w_m_rdata;
   assign w_d_rdata = w_m_rdata;
   assign w_busy    = (r_state != ST_IDLE);

   a_ack_only_busy: assert property (@(posedge w_clk) disable iff (!w_rst_n)
      w_m_ack |-> (r_state != ST_IDLE));

endmodule

// File: tb/tb_m_mem_arbiter.sv
// Directed bench for m_mem_arbiter: a FAIR=1 instance under full checks plus a FAIR=0 instance for the tie rule.
// Inputs change just after the falling edge; outputs are checked 1 time unit later, well before the rising edge.
module tb_m_mem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        i_req, i_kill, i_ack, i_ack2;
   logic [31:0] i_addr, i_rdata, i_rdata2;
   logic        d_req, d_we, d_ack, d_ack2;
   logic [3:0]  d_be;
   logic [31:0] d_addr, d_wdata, d_rdata, d_rdata2;
   logic        m_req, m_we, m_ack, m_req2, m_we2, m_ack2;
   logic [3:0]  m_be, m_be2;
   logic [31:0] m_addr, m_wdata, m_rdata, m_addr2, m_wdata2;
   logic        busy, busy2;
   logic        auto_ack, m_ack_man;

   int checks   = 0;
   int failures = 0;

   assign m_ack  = auto_ack ? m_req : m_ack_man;
   assign m_ack2 = m_req2;

   m_mem_arbiter #(.AW(32), .DW(32), .FAIR(1)) dut (
      .w_clk(clk), .w_rst_n(rst_n),
      .w_i_req(i_req), .w_i_addr(i_addr), .w_i_kill(i_kill),
      .w_i_ack(i_ack), .w_i_rdata(i_rdata),
      .w_d_req(d_req), .w_d_we(d_we), .w_d_be(d_be), .w_d_addr(d_addr),
      .w_d_wdata(d_wdata), .w_d_ack(d_ack), .w_d_rdata(d_rdata),
      .w_m_req(m_req), .w_m_we(m_we), .w_m_be(m_be), .w_m_addr(m_addr),
      .w_m_wdata(m_wdata), .w_m_ack(m_ack), .w_m_rdata(m_rdata),
      .w_busy(busy)
   );

   m_mem_arbiter #(.AW(32), .DW(32), .FAIR(0)) dut_nf (
      .w_clk(clk), .w_rst_n(rst_n),
      .w_i_req(i_req), .w_i_addr(i_addr), .w_i_kill(i_kill),
      .w_i_ack(i_ack2), .w_i_rdata(i_rdata2),
      .w_d_req(d_req), .w_d_we(d_we), .w_d_be(d_be), .w_d_addr(d_addr),
      .w_d_wdata(d_wdata), .w_d_ack(d_ack2), .w_d_rdata(d_rdata2),
      .w_m_req(m_req2), .w_m_we(m_we2), .w_m_be(m_be2), .w_m_addr(m_addr2),
      .w_m_wdata(m_wdata2), .w_m_ack(m_ack2), .w_m_rdata(m_rdata),
      .w_busy(busy2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; i_req = 0; i_kill = 0; i_addr = 0;
      d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
      m_rdata = 0; auto_ack = 0; m_ack_man = 0;

      // Reset state
      #12;
      chk("rst_m_req", m_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_m_addr", m_addr, 0);
      chk("rst_m_we", m_we, 0);
      chk("rst_acks", {i_ack, d_ack}, 0);
      cyc(); rst_n = 1'b1;

      // Continuous I and D with a zero-wait memory: FAIR=1 gives D,I,D,I; FAIR=0 gives D every time
      cyc();
      auto_ack = 1; i_req = 1; i_addr = 32'h4; d_req = 1; d_we = 0; d_addr = 32'h100;
      for (int k = 1; k <= 8; k++) begin
         cyc(); #1;
         chk($sformatf("fair_d_ack_%0d", k), d_ack, (k % 4) == 1);
         chk($sformatf("fair_i_ack_%0d", k), i_ack, (k % 4) == 3);
         chk($sformatf("nofair_d_ack_%0d", k), d_ack2, (k % 2) == 1);
         chk($sformatf("nofair_i_ack_%0d", k), i_ack2, 0);
         if (k == 8) begin
            i_req = 0; d_req = 0;
         end
      end
      cyc(); auto_ack = 0; #1;
      chk("fair_end_busy", busy, 0);

      // Single fetch, memory acks on the third busy cycle
      cyc(); i_req = 1; i_addr = 32'h10; #1;
      chk("f_idle_m_req", m_req, 0);
      cyc(); #1;
      chk("f_m_req", m_req, 1);
      chk("f_m_addr", m_addr, 32'h10);
      chk("f_m_we", m_we, 0);
      chk("f_busy1", busy, 1);
      chk("f_no_ack1", i_ack, 0);
      cyc(); #1;
      chk("f_busy2", busy, 1);
      chk("f_no_ack2", i_ack, 0);
      cyc(); m_ack_man = 1; m_rdata = 32'h00000013; #1;
      chk("f_busy3", busy, 1);
      chk("f_i_ack", i_ack, 1);
      chk("f_i_rdata", i_rdata, 32'h00000013);
      chk("f_no_d_ack", d_ack, 0);
      cyc(); m_ack_man = 0; i_req = 0; #1;
      chk("f_after_busy", busy, 0);
      chk("f_after_m_req", m_req, 0);

      // Store while idle
      cyc(); d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h80; d_wdata = 32'hDEADBEEF;
      cyc(); m_ack_man = 1; #1;
      chk("s_m_req", m_req, 1);
      chk("s_m_we", m_we, 1);
      chk("s_m_be", m_be, 4'b0011);
      chk("s_m_addr", m_addr, 32'h80);
      chk("s_m_wdata", m_wdata, 32'hDEADBEEF);
      chk("s_d_ack", d_ack, 1);
      chk("s_no_i_ack", i_ack, 0);
      cyc(); m_ack_man = 0; d_req = 0; d_we = 0; d_be = 0; #1;
      chk("s_after_busy", busy, 0);

      // Kill in flight with a load pending; last grant was D so the fetch wins the tie
      cyc(); i_req = 1; i_addr = 32'h20; d_req = 1; d_addr = 32'h40; d_wdata = 0;
      cyc(); i_kill = 1; #1;
      chk("k_m_addr", m_addr, 32'h20);
      chk("k_m_we", m_we, 0);
      cyc(); i_kill = 0; i_req = 0; #1;
      chk("k_busy_ik", busy, 1);
      cyc(); m_ack_man = 1; m_rdata = 32'h12345678; #1;
      chk("k_no_i_ack", i_ack, 0);
      chk("k_no_d_ack", d_ack, 0);
      cyc(); m_ack_man = 0; #1;
      chk("k_idle_busy", busy, 0);
      chk("k_idle_m_req", m_req, 0);
      cyc(); m_ack_man = 1; m_rdata = 32'hCAFE0001; #1;
      chk("k_d_m_addr", m_addr, 32'h40);
      chk("k_d_ack", d_ack, 1);
      chk("k_d_rdata", d_rdata, 32'hCAFE0001);
      cyc(); m_ack_man = 0; d_req = 0; #1;
      chk("k_d_done", busy, 0);

      // Kill in the same cycle as the memory ack
      cyc(); i_req = 1; i_addr = 32'h30;
      cyc(); m_ack_man = 1; i_kill = 1; #1;
      chk("ka_m_addr", m_addr, 32'h30);
      chk("ka_no_i_ack", i_ack, 0);
      cyc(); m_ack_man = 0; i_kill = 0; i_req = 0; #1;
      chk("ka_idle", busy, 0);

      // Kill in IDLE blocks that cycle's grant; the fetch is granted once the kill drops
      cyc(); i_req = 1; i_addr = 32'h34; i_kill = 1;
      cyc(); i_kill = 0; #1;
      chk("ki_no_grant", m_req, 0);
      chk("ki_busy", busy, 0);
      cyc(); m_ack_man = 1; m_rdata = 32'h00100093; #1;
      chk("ki_m_addr", m_addr, 32'h34);
      chk("ki_i_ack", i_ack, 1);
      chk("ki_i_rdata", i_rdata, 32'h00100093);
      cyc(); m_ack_man = 0; i_req = 0;

      // Asynchronous reset in the middle of BUSY_D
      cyc(); d_req = 1; d_we = 0; d_addr = 32'h44;
      cyc(); #1;
      chk("r_m_req_before", m_req, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("r_m_req", m_req, 0);
      chk("r_busy", busy, 0);
      chk("r_m_addr", m_addr, 0);
      chk("r_d_ack", d_ack, 0);
      cyc(); d_req = 0; rst_n = 1'b1;
      cyc(); i_req = 1; i_addr = 32'h50;
      cyc(); m_ack_man = 1; m_rdata = 32'h0000A5A5; #1;
      chk("r_post_m_addr", m_addr, 32'h50);
      chk("r_post_i_ack", i_ack, 1);
      cyc(); m_ack_man = 0; i_req = 0; #1;
      chk("r_post_idle", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
